// File: rtl/booth_multiplier_seq_pkg.sv
// Shared constants and state encoding for the sequential radix-4 Booth multiplier.
// Operand width, iteration count and derived datapath widths live here.
package booth_multiplier_seq_pkg;

   localparam int WIDTH = 32;
   localparam int ITER  = WIDTH / 2;
   localparam int ACC_W = WIDTH + 2;
   localparam int CNT_W = $clog2(ITER);
   localparam int PROD_W = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps a {Q[1],Q[0],Q[-1]} bit group to 0, +/-M or +/-2M.
// M arrives already sign-extended to ACC_W bits, so doubling it cannot overflow.
module booth_recoder
   import booth_multiplier_seq_pkg::*;
(
   input  logic [2:0]              group,
   input  logic signed [ACC_W-1:0] m,
   output logic signed [ACC_W-1:0] addend
);

   logic signed [ACC_W-1:0] m_x2;

   assign m_x2 = m <<< 1;

   always_comb begin
      addend = '0;
      unique case (group)
         3'b001, 3'b010: addend = m;
         3'b011:         addend = m_x2;
         3'b100:         addend = -m_x2;
         3'b101, 3'b110: addend = -m;
         default:        addend = '0;
      endcase
   end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential signed 32x32 multiplier retiring two multiplier bits per clock.
// A fixed 16-iteration run keeps latency independent of operand values.
module booth_multiplier_seq
   import booth_multiplier_seq_pkg::*;
(
   input  logic                clock,
   input  logic                clear,
   input  logic                start,
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   output logic [PROD_W-1:0]   C,
   output logic                busy,
   output logic                done
);

   state_t state;
   state_t next_state;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] m;
   logic signed [ACC_W-1:0] addend;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] acc_next;
   logic [WIDTH-1:0]        q;
   logic [WIDTH-1:0]        q_next;
   logic                    q_m1;
   logic [CNT_W-1:0]        cnt;
   logic [PROD_W-1:0]       product;
   logic                    last_iter;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

   booth_recoder u_recoder (
      .group  ({q[1:0], q_m1}),
      .m      (m),
      .addend (addend)
   );

   // One iteration: add the recoded multiple, then arithmetic-shift {acc,Q,Q[-1]} right by two.
   assign sum       = acc + addend;
   assign acc_next  = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
   assign q_next    = {sum[1:0], q[WIDTH-1:2]};
   assign last_iter = (cnt == LAST_CNT);

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last_iter) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Datapath registers; C is only rewritten on the edge that enters DONE.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         acc     <= '0;
         m       <= '0;
         q       <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  m    <= {{2{A[WIDTH-1]}}, A};
                  q    <= B;
                  acc  <= '0;
                  q_m1 <= 1'b0;
                  cnt  <= '0;
               end
            end
            RUN: begin
               acc  <= acc_next;
               q    <= q_next;
               q_m1 <= q[1];
               cnt  <= cnt + CNT_W'(1);
               if (last_iter) begin
                  product <= {acc_next[WIDTH-1:0], q_next};
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign C    = product;
   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: doc/booth_multiplier_seq.md
BOOTH_MULTIPLIER_SEQ -- requirements
Module: booth_multiplier_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 clear  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 A  input  32  multiplicand, signed two's complement; captured when start is accepted.
REQ-006 B  input  32  multiplier, signed two's complement; captured when start is accepted.
REQ-007 C  output  64  signed product, registered; stable except on the edge entering DONE.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  high for exactly one cycle, in DONE.

Function
REQ-010 The FSM SHALL have three states, with these transitions:
- IDLE to RUN when start=1.
- RUN to DONE after the 16th iteration.
- DONE to IDLE unconditionally.
REQ-011 Start acceptance SHALL occur on an IDLE edge with start=1 and SHALL:
- latch A into M (sign-extended to 34 bits);
- latch B into Q;
- set the accumulator to 0, the appended bit Q[-1] to 0 and iteration counter cnt to 0;
- move to RUN.
REQ-012 Each RUN edge SHALL apply one radix-4 bit-pair iteration:
- recode {Q[1],Q[0],Q[-1]} to 0, +M, +2M, -M or -2M;
- add the recoded value to the accumulator;
- arithmetic-shift {acc,Q,Q[-1]} right by 2;
- increment cnt.
REQ-013 Recoding table (000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M) SHALL be exact.
REQ-014 The accumulator SHALL be 34 bits wide so that +/-2M never overflows.
REQ-015 When cnt=15 on a RUN edge, that edge SHALL complete the last iteration, load the final {acc[31:0],Q} into C and enter DONE.
REQ-016 Latency SHALL be fixed: done is high in the 17th cycle after the start-accept edge, and is independent of operand values.
REQ-017 start asserted in RUN or DONE SHALL be ignored; there is no queuing.
REQ-018 start held high continuously SHALL produce back-to-back operations with one IDLE cycle between done and the next acceptance.
REQ-019 Changing A or B after acceptance SHALL NOT affect the in-flight result.
REQ-020 The product SHALL be correct for every signed pair, including -2^31 * -2^31 = 0x4000000000000000.
REQ-021 C SHALL hold its last value through IDLE, RUN and the next start until the next DONE entry.

Reset
REQ-022 clear=1 SHALL, asynchronously and at any point including mid-RUN, force:
- state to IDLE;
- C, acc, Q, M, Q[-1] and cnt to 0;
- busy and done to 0.
REQ-023 After clear deasserts, the first start SHALL be accepted on the first clock edge with start=1.
REQ-024 An operation interrupted by clear SHALL never assert done.

Structure
REQ-025 A shared package/header SHALL hold: WIDTH=32, ITER=16 and the state encodings IDLE/RUN/DONE.
REQ-026 One combinational sub-module, booth_recoder, SHALL map the 3-bit group and M to the 34-bit signed addend.
REQ-027 The adder, shift register, counter and FSM SHALL reside in booth_multiplier_seq.

Verification
REQ-028 A=7, B=3, start pulse -> done exactly 17 cycles later, C=0x0000000000000015, busy high for 16 cycles.
REQ-029 A=-1 (0xFFFFFFFF), B=-1 -> C=0x0000000000000001; A=0x80000000, B=0x80000000 -> C=0x4000000000000000.
REQ-030 A=0x7FFFFFFF, B=-2 -> C=0xFFFFFFFF00000002; A=0, B=0x12345678 -> C=0.
REQ-031 start and A/B changed during RUN (A=5, B=6 accepted, then A=9 mid-run) -> single done, C=30, second start ignored.
REQ-032 clear pulse at iteration 8 of A=100, B=200 -> C=0 and done never asserts; a following start with A=100, B=200 -> C=20000.
REQ-033 Random signed pairs (>=10k) against a reference model -> all match; done never high for two consecutive cycles.
